// File: rtl/move_sequencer_pkg.sv
// Shared move-code definitions for the keyboard front end, cube datapath and sequencer.
package move_sequencer_pkg;

  localparam int unsigned CODE_W = 5;

  // Face/axis move codes; the primed variant follows its base move.
  localparam logic [CODE_W-1:0] MOVE_R       = 5'd0;
  localparam logic [CODE_W-1:0] MOVE_R_PRIME = 5'd1;
  localparam logic [CODE_W-1:0] MOVE_F       = 5'd2;
  localparam logic [CODE_W-1:0] MOVE_F_PRIME = 5'd3;
  localparam logic [CODE_W-1:0] MOVE_U       = 5'd4;
  localparam logic [CODE_W-1:0] MOVE_U_PRIME = 5'd5;
  localparam logic [CODE_W-1:0] MOVE_L       = 5'd6;
  localparam logic [CODE_W-1:0] MOVE_L_PRIME = 5'd7;
  localparam logic [CODE_W-1:0] MOVE_X       = 5'd8;
  localparam logic [CODE_W-1:0] MOVE_X_PRIME = 5'd9;
  localparam logic [CODE_W-1:0] MOVE_Y       = 5'd10;
  localparam logic [CODE_W-1:0] MOVE_Y_PRIME = 5'd11;
  localparam logic [CODE_W-1:0] MOVE_Z       = 5'd12;
  localparam logic [CODE_W-1:0] MOVE_Z_PRIME = 5'd13;
  localparam logic [CODE_W-1:0] MOVE_B       = 5'd14;
  localparam logic [CODE_W-1:0] MOVE_B_PRIME = 5'd15;
  localparam logic [CODE_W-1:0] MOVE_D       = 5'd16;
  localparam logic [CODE_W-1:0] MOVE_D_PRIME = 5'd17;

  localparam logic [CODE_W-1:0] NO_CMD   = 5'b11111;
  localparam logic [CODE_W-1:0] MOVE_MAX = 5'd17;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StSettle
  } seq_state_e;

  function automatic logic is_move(input logic [CODE_W-1:0] code);
    return code <= MOVE_MAX;
  endfunction

endpackage

// File: rtl/move_sequencer_fifo.sv
// Circular move FIFO with separately tracked occupancy and a synchronous flush.
module move_fifo
  import move_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [CODE_W-1:0]            din,
  output logic [CODE_W-1:0]            dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [CODE_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  // Full is judged on start-of-cycle occupancy, so a same-cycle pop never frees a slot.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Move scheduler: arbitrates keyboard and automatic requests into a FIFO and issues
// one move at a time to the rotation datapath, with a settle gap after each move.
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CODE_W-1:0]          kb_cmd,
  input  logic                       kb_changed,
  input  logic [CODE_W-1:0]          auto_cmd,
  input  logic                       auto_valid,
  output logic                       auto_ready,
  input  logic                       flush,
  output logic [CODE_W-1:0]          mv_cmd,
  output logic                       mv_valid,
  input  logic                       mv_ready,
  input  logic                       mv_done,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       kb_drop,
  output logic                       bad_code
);

  localparam int unsigned SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);

  seq_state_e        state_q, state_d;
  logic [CODE_W-1:0] mv_cmd_d, fifo_dout, fifo_din;
  logic              mv_valid_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic              kb_changed_d;
  logic              kb_edge, kb_req, kb_bad, auto_fire, auto_ok;
  logic              push, pop, full, empty;

  // Request decode: one keyboard request per key press; NO_CMD is simply "no key".
  assign kb_edge    = kb_changed && !kb_changed_d;
  assign kb_req     = kb_edge && is_move(kb_cmd);
  assign kb_bad     = kb_edge && !is_move(kb_cmd) && (kb_cmd != NO_CMD);
  assign auto_ready = !full && !kb_req && !flush && !rst;
  assign auto_fire  = auto_valid && auto_ready;
  assign auto_ok    = auto_fire && is_move(auto_cmd);
  assign push       = !flush && ((kb_req && !full) || auto_ok);
  assign fifo_din   = kb_req ? kb_cmd : auto_cmd;
  assign busy       = (state_q != StIdle) || !empty;

  move_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Issue FSM next state; a move in flight always completes, even across a flush.
  always_comb begin
    state_d    = state_q;
    mv_cmd_d   = mv_cmd;
    mv_valid_d = mv_valid;
    settle_d   = settle_q;
    pop        = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty && !flush) begin
          pop        = 1'b1;
          mv_cmd_d   = fifo_dout;
          mv_valid_d = 1'b1;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (mv_valid && mv_ready) begin
          mv_valid_d = 1'b0;
          state_d    = StWaitDone;
        end
      end
      StWaitDone: begin
        if (mv_done) begin
          if (SETTLE_CYCLES == 0) begin
            state_d = StIdle;
          end else begin
            settle_d = SETTLE_LOAD;
            state_d  = StSettle;
          end
        end
      end
      StSettle: begin
        if (settle_q <= SW'(1)) begin
          settle_d = '0;
          state_d  = StIdle;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, issued move, edge history and the registered status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      mv_cmd       <= NO_CMD;
      mv_valid     <= 1'b0;
      settle_q     <= '0;
      kb_changed_d <= 1'b0;
      kb_drop      <= 1'b0;
      bad_code     <= 1'b0;
    end else begin
      state_q      <= state_d;
      mv_cmd       <= mv_cmd_d;
      mv_valid     <= mv_valid_d;
      settle_q     <= settle_d;
      kb_changed_d <= kb_changed;
      kb_drop      <= kb_req && full && !flush;
      bad_code     <= kb_bad || (auto_fire && !is_move(auto_cmd));
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic, all compared every cycle
// against a queue-based behavioural model of the sequencer.
module tb_move_sequencer;
  import move_sequencer_pkg::*;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned CW     = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    kb_cmd = NO_CMD;
  logic          kb_changed = 1'b0;
  logic [4:0]    auto_cmd = 5'd0;
  logic          auto_valid = 1'b0;
  logic          auto_ready;
  logic          flush = 1'b0;
  logic [4:0]    mv_cmd;
  logic          mv_valid;
  logic          mv_ready = 1'b0;
  logic          mv_done = 1'b0;
  logic          busy;
  logic [CW-1:0] count;
  logic          kb_drop;
  logic          bad_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  move_sequencer #(.DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .kb_cmd     (kb_cmd),
    .kb_changed (kb_changed),
    .auto_cmd   (auto_cmd),
    .auto_valid (auto_valid),
    .auto_ready (auto_ready),
    .flush      (flush),
    .mv_cmd     (mv_cmd),
    .mv_valid   (mv_valid),
    .mv_ready   (mv_ready),
    .mv_done    (mv_done),
    .busy       (busy),
    .count      (count),
    .kb_drop    (kb_drop),
    .bad_code   (bad_code)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [4:0] m_q[$];     // queued moves in arrival order
  bit         m_kb_prev;  // keyboard level seen last cycle
  bit         m_valid;    // a move is offered to the datapath
  logic [4:0] m_cmd;      // last move offered
  bit         m_wait;     // handed over, datapath still working
  int         m_settle;   // settle cycles still to sit out
  bit         m_drop, m_bad;

  task automatic m_reset();
    m_q.delete();
    m_kb_prev = 0; m_valid = 0; m_cmd = NO_CMD; m_wait = 0;
    m_settle = 0; m_drop = 0; m_bad = 0;
  endtask

  task automatic compare_and_step();
    bit full, kbedge, kbreq, kbbad, idle, exp_ar, afire, do_push, issue;
    logic [4:0] val;
    if (rst) m_reset();
    full   = (m_q.size() == DEPTH);
    kbedge = kb_changed && !m_kb_prev;
    kbreq  = kbedge && (kb_cmd <= 5'd17);
    kbbad  = kbedge && (kb_cmd > 5'd17) && (kb_cmd != 5'd31);
    idle   = !m_valid && !m_wait && (m_settle == 0);
    exp_ar = !full && !kbreq && !flush && !rst;
    check("auto_ready", auto_ready, exp_ar);
    check("busy", busy, !idle || (m_q.size() > 0));
    check("count", count, m_q.size());
    check("mv_valid", mv_valid, m_valid);
    check("mv_cmd", mv_cmd, m_cmd);
    check("kb_drop", kb_drop, m_drop);
    check("bad_code", bad_code, m_bad);
    if (rst) return;
    afire   = auto_valid && exp_ar;
    do_push = 0;
    val     = 5'd0;
    if (!flush) begin
      if (kbreq) begin
        do_push = !full;
        val     = kb_cmd;
      end else if (afire && auto_cmd <= 5'd17) begin
        do_push = 1;
        val     = auto_cmd;
      end
    end
    issue = idle && (m_q.size() > 0) && !flush;
    if (flush) m_q.delete();
    if (m_valid) begin
      if (mv_ready) begin m_valid = 0; m_wait = 1; end
    end else if (m_wait) begin
      if (mv_done) begin m_wait = 0; m_settle = SETTLE; end
    end else if (m_settle > 0) begin
      m_settle--;
    end else if (issue) begin
      m_cmd   = m_q.pop_front();
      m_valid = 1;
    end
    if (do_push) m_q.push_back(val);
    m_drop    = kbreq && full && !flush;
    m_bad     = kbbad || (afire && auto_cmd > 5'd17);
    m_kb_prev = kb_changed;
  endtask

  // Compare process: inputs change at the falling edge, outputs are checked 2 ns later.
  always @(negedge clk) begin
    #2;
    compare_and_step();
  end

  // ---------------- driver helpers ----------------
  task automatic next();
    @(negedge clk);
    mv_done = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin next(); #3; n++; end
    check("idle_reached", busy, 0);
  endtask

  // Accept the next issued move, check its code, then report it done.
  task automatic complete_one(input logic [4:0] exp_code);
    int n = 0;
    next(); mv_ready = 1'b1; #3;
    while (!mv_valid && n < 50) begin next(); #3; n++; end
    check("issue_present", mv_valid, 1);
    check("issue_code", mv_cmd, exp_code);
    next(); mv_ready = 1'b0; #3;
    next(); mv_done = 1'b1; #3;
  endtask

  task automatic auto_push(input logic [4:0] code, output bit ok);
    int n = 0;
    next(); auto_valid = 1'b1; auto_cmd = code; #3;
    while (!auto_ready && n < 12) begin next(); #3; n++; end
    ok = auto_ready;
  endtask

  function automatic logic [4:0] rand_code();
    int r = $urandom_range(0, 9);
    if (r < 7) return 5'($urandom_range(0, 17));
    if (r < 9) return 5'($urandom_range(18, 30));
    return NO_CMD;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int peak;
    bit stayed;
    logic [4:0] exp_q[$];
    logic [4:0] c;

    repeat (3) @(negedge clk);
    check("auto_ready_in_reset", auto_ready, 0);
    next(); rst = 1'b0; #3;
    check("reset_count", count, 0);
    check("reset_mv_cmd", mv_cmd, 31);
    check("reset_mv_valid", mv_valid, 0);
    check("reset_auto_ready", auto_ready, 1);
    check("reset_busy", busy, 0);

    // Keyboard f: two cycles to mv_valid, then exactly SETTLE busy cycles after done.
    next(); kb_changed = 1'b1; kb_cmd = MOVE_F; #3;
    next(); #3;
    check("kb_count_t1", count, 1);
    next(); #3;
    check("kb_valid_t2", mv_valid, 1);
    check("kb_cmd_t2", mv_cmd, 2);
    next(); mv_ready = 1'b1; #3;
    next(); mv_ready = 1'b0; kb_changed = 1'b0; #3;
    check("wait_done_valid", mv_valid, 0);
    check("wait_done_busy", busy, 1);
    next(); mv_done = 1'b1; #3;
    begin
      int n = 0;
      for (int i = 0; i < 20; i++) begin
        next(); #3;
        if (!busy) break;
        n++;
      end
      check("settle_busy_cycles", n, SETTLE);
    end

    // Held key: a single enqueue.
    peak = 0;
    next(); kb_changed = 1'b1; kb_cmd = MOVE_U_PRIME; mv_ready = 1'b1; #3;
    for (int i = 0; i < 50; i++) begin
      if (int'(count) > peak) peak = int'(count);
      next(); #3;
    end
    check("held_key_peak", peak, 1);
    kb_changed = 1'b0; mv_ready = 1'b0;
    next(); mv_done = 1'b1; #3;
    wait_idle();

    // Fill: datapath stalled, auto streams 0..9.
    for (int i = 0; i < 10; i++) begin
      auto_push(5'(i), ok);
      if (i < 9) check("auto_accept", ok, 1);
      else check("auto_blocked_full", ok, 0);
    end
    next(); auto_valid = 1'b0; #3;
    check("full_count", count, 8);
    check("full_auto_ready", auto_ready, 0);
    next(); kb_changed = 1'b1; kb_cmd = MOVE_R_PRIME; #3;
    next(); kb_changed = 1'b0; #3;
    check("kb_drop_pulse", kb_drop, 1);
    check("kb_drop_count", count, 8);
    for (int i = 0; i < 9; i++) complete_one(5'(i));
    wait_idle();

    // Keyboard beats auto in the same cycle.
    next(); kb_changed = 1'b1; kb_cmd = MOVE_U; auto_valid = 1'b1; auto_cmd = MOVE_L; #3;
    check("arb_auto_blocked", auto_ready, 0);
    next(); #3;
    check("arb_auto_next", auto_ready, 1);
    next(); auto_valid = 1'b0; kb_changed = 1'b0;
    complete_one(MOVE_U);
    complete_one(MOVE_L);
    wait_idle();

    // Bad auto code, then flush while a move waits for done.
    next(); auto_valid = 1'b1; auto_cmd = 5'd20; #3;
    check("bad_accepted", auto_ready, 1);
    next(); auto_valid = 1'b0; #3;
    check("bad_code_pulse", bad_code, 1);
    check("bad_count", count, 0);
    auto_push(MOVE_Y_PRIME, ok);
    next(); auto_valid = 1'b0; mv_ready = 1'b1; #3;
    for (int i = 0; i < 10 && !mv_valid; i++) begin next(); #3; end
    check("flush_issue_code", mv_cmd, MOVE_Y_PRIME);
    next(); mv_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      next(); auto_valid = 1'b1; auto_cmd = 5'(12 + k); #3;
    end
    next(); auto_valid = 1'b0; #3;
    check("pre_flush_count", count, 3);
    next(); flush = 1'b1; #3;
    next(); #3;
    check("post_flush_count", count, 0);
    check("post_flush_busy", busy, 1);
    next(); mv_done = 1'b1; #3;
    wait_idle();
    stayed = 1;
    for (int i = 0; i < 10; i++) begin
      next(); #3;
      if (busy || mv_valid) stayed = 0;
    end
    check("flush_stays_idle", stayed, 1);

    // Pointer wrap: 20 moves in batches of five.
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 5; k++) begin
        c = 5'($urandom_range(0, 17));
        auto_push(c, ok);
        check("wrap_accept", ok, 1);
        exp_q.push_back(c);
      end
      next(); auto_valid = 1'b0;
      while (exp_q.size() > 0) complete_one(exp_q.pop_front());
      wait_idle();
    end

    // Asynchronous reset while settling.
    for (int k = 0; k < 3; k++) begin
      auto_push(5'(k + 3), ok);
    end
    next(); auto_valid = 1'b0;
    complete_one(5'd3);
    next(); #3;
    next(); rst = 1'b1; #1;
    check("rst_mv_valid", mv_valid, 0);
    check("rst_mv_cmd", mv_cmd, 31);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_kb_drop", kb_drop, 0);
    check("rst_bad_code", bad_code, 0);
    check("rst_auto_ready", auto_ready, 0);
    next(); rst = 1'b0;

    // Random traffic against the model.
    repeat (3000) begin
      next();
      if ($urandom_range(0, 5) == 0) kb_changed = !kb_changed;
      kb_cmd     = rand_code();
      auto_valid = ($urandom_range(0, 2) == 0);
      auto_cmd   = rand_code();
      mv_ready   = ($urandom_range(0, 1) == 1);
      mv_done    = ($urandom_range(0, 3) == 0);
      flush      = ($urandom_range(0, 60) == 0);
      rst        = ($urandom_range(0, 400) == 0);
    end
    next();
    rst = 1'b0; kb_changed = 1'b0; auto_valid = 1'b0; mv_ready = 1'b0;
    next(); #3;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
